// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file definitions: geometry, clear-sequence bounds and controller states.
// The register file and the writeback arbiter both import this package.
package regfile_defs;

  localparam int RF_DATA_W      = 32;
  localparam int RF_ADDR_W      = 5;
  localparam int RF_NUM_REGS    = 1 << RF_ADDR_W;
  localparam int RF_ZERO_REG    = 0;
  localparam int RF_CLEAR_FIRST = 1;
  localparam int RF_CLEAR_LAST  = RF_NUM_REGS - 1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } wb_state_e;

  // Pointer width for a requester index; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin selector: the first asserted request strictly after last_grant wins,
// wrapping back through requester 0 up to and including last_grant.
module rr_arbiter
  import regfile_defs::*;
#(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   winner,
  output logic               any
);

  always_comb begin
    grant  = '0;
    winner = last_grant;
    any    = 1'b0;
    // Two passes give the wrapped search order without a variable index.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && req[i] && (i > int'(last_grant))) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        winner   = PTR_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && req[i] && (i <= int'(last_grant))) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        winner   = PTR_W'(i);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-port controller for the register file: round-robin writeback arbitration
// plus a clear sequencer that zeroes registers 1..31, all through registered outputs.
module regfile_wb_arbiter
  import regfile_defs::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = RF_DATA_W,
  parameter int ADDR_W  = RF_ADDR_W
) (
  input  logic                      clock,
  input  logic                      ctrl_reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      clear_start,
  output logic                      clear_busy,
  output logic                      clear_done,
  output logic                      ctrl_writeEn,
  output logic [ADDR_W-1:0]         ctrl_writeReg,
  output logic [DATA_W-1:0]         data_writeReg
);

  localparam int PTR_W = ptr_width(NUM_REQ);
  localparam logic [ADDR_W-1:0] CNT_FIRST = ADDR_W'(RF_CLEAR_FIRST);
  localparam logic [ADDR_W-1:0] CNT_LAST  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ZERO_IDX  = ADDR_W'(RF_ZERO_REG);

  wb_state_e           state;
  logic [ADDR_W-1:0]   cnt;
  logic [PTR_W-1:0]    last_grant;
  logic [NUM_REQ-1:0]  grant;
  logic [PTR_W-1:0]    winner;
  logic                any_req;
  logic                take;
  logic [ADDR_W-1:0]   win_reg;
  logic [DATA_W-1:0]   win_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .winner     (winner),
    .any        (any_req)
  );

  always_comb begin
    win_reg  = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_reg  = req_reg[i*ADDR_W +: ADDR_W];
        win_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // A pending clear outranks every requester in the same cycle.
  assign take      = (state == IDLE) && !clear_start && any_req;
  assign req_ready = take ? grant : '0;

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state         <= IDLE;
      cnt           <= '0;
      last_grant    <= PTR_W'(NUM_REQ - 1);
      clear_busy    <= 1'b0;
      clear_done    <= 1'b0;
      ctrl_writeEn  <= 1'b0;
      ctrl_writeReg <= '0;
      data_writeReg <= '0;
    end else begin
      ctrl_writeEn <= 1'b0;
      clear_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_start) begin
            state      <= CLEAR;
            cnt        <= CNT_FIRST;
            clear_busy <= 1'b1;
          end else if (take) begin
            last_grant    <= winner;
            ctrl_writeEn  <= (win_reg != ZERO_IDX);
            ctrl_writeReg <= win_reg;
            data_writeReg <= win_data;
          end
        end
        CLEAR: begin
          ctrl_writeEn  <= 1'b1;
          ctrl_writeReg <= cnt;
          data_writeReg <= '0;
          if (cnt == CNT_LAST) begin
            state      <= IDLE;
            clear_busy <= 1'b0;
            clear_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: randomized writeback traffic and clear sequences against a
// queue-based behavioural model, with directed scenarios pinning the model itself.
module tb_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam logic [31:0] DEAD = 32'h0000_DEAD;

  logic              clock = 1'b0;
  logic              ctrl_reset;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_reg;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              clear_start;
  logic              clear_busy;
  logic              clear_done;
  logic              ctrl_writeEn;
  logic [AW-1:0]     ctrl_writeReg;
  logic [DW-1:0]     data_writeReg;

  regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clock         (clock),
    .ctrl_reset    (ctrl_reset),
    .req_valid     (req_valid),
    .req_reg       (req_reg),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .clear_start   (clear_start),
    .clear_busy    (clear_busy),
    .clear_done    (clear_done),
    .ctrl_writeEn  (ctrl_writeEn),
    .ctrl_writeReg (ctrl_writeReg),
    .data_writeReg (data_writeReg)
  );

  always #5 clock = ~clock;

  // requester side
  logic          v [N];
  logic [AW-1:0] r [N];
  logic [DW-1:0] d [N];

  always_comb begin
    req_valid = '0;
    req_reg   = '0;
    req_data  = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = v[i];
      req_reg[i*AW +: AW]   = r[i];
      req_data[i*DW +: DW]  = d[i];
    end
  end

  // behavioural model
  int            clr_q[$];
  int            m_last;
  logic [31:0]   m_mem [32];
  logic [31:0]   dut_mem [32];
  logic          e_en, e_busy, e_done, e_known, outs_valid;
  logic [AW-1:0] e_reg;
  logic [DW-1:0] e_data;

  // sampled DUT outputs of the most recent cycle
  logic [N-1:0]  s_ready;
  logic          s_en, s_busy, s_done;
  logic [AW-1:0] s_reg;
  logic [DW-1:0] s_data;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    logic [N-1:0] exp_ready;
    logic         taken [N];
    logic         found;
    int           idx;
    @(negedge clock);
    s_ready = req_ready;
    s_en    = ctrl_writeEn;
    s_reg   = ctrl_writeReg;
    s_data  = data_writeReg;
    s_busy  = clear_busy;
    s_done  = clear_done;
    if (outs_valid) begin
      chk("writeEn", 32'(s_en), 32'(e_en));
      chk("clear_busy", 32'(s_busy), 32'(e_busy));
      chk("clear_done", 32'(s_done), 32'(e_done));
      if (e_known) begin
        chk("writeReg", 32'(s_reg), 32'(e_reg));
        chk("writeData", s_data, e_data);
      end
    end
    if (s_en && s_reg != 0) dut_mem[s_reg] = s_data;

    exp_ready = '0;
    if (ctrl_reset) begin
      clr_q.delete();
      m_last = N - 1;
      {e_en, e_busy, e_done} = 3'b000;
      e_reg = '0; e_data = '0; e_known = 1'b1; outs_valid = 1'b1;
    end else begin
      e_en = 1'b0; e_done = 1'b0;
      if (clr_q.size() > 0) begin
        idx = clr_q.pop_front();
        e_en = 1'b1; e_reg = AW'(idx); e_data = '0; e_known = 1'b1;
        m_mem[idx] = '0;
        e_busy = (clr_q.size() > 0);
        e_done = (clr_q.size() == 0);
      end else if (clear_start) begin
        for (int k = 1; k < 32; k++) clr_q.push_back(k);
        e_busy = 1'b1;
      end else begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          idx = (m_last + k) % N;
          if (!found && v[idx]) begin
            found = 1'b1;
            exp_ready[idx] = 1'b1;
            m_last = idx;
            if (r[idx] != 0) begin
              e_en = 1'b1; e_reg = r[idx]; e_data = d[idx]; e_known = 1'b1;
              m_mem[r[idx]] = d[idx];
            end else begin
              e_known = 1'b0;
            end
          end
        end
      end
      chk("req_ready", 32'(s_ready), 32'(exp_ready));
    end
    for (int i = 0; i < N; i++) taken[i] = v[i] && s_ready[i] && !ctrl_reset;
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) if (taken[i]) v[i] = 1'b0;
    clear_start = 1'b0;
  endtask

  task automatic write_one(input int i, input int rg, input logic [31:0] dt);
    int n;
    v[i] = 1'b1; r[i] = AW'(rg); d[i] = dt;
    n = 0;
    while (v[i] && n < 50) begin
      step();
      n++;
    end
    if (v[i]) begin
      chk("grant_timeout", 32'(v[i]), 32'd0);
      v[i] = 1'b0;
    end
  endtask

  task automatic drain_requests();
    int n;
    n = 0;
    while ((v[0] || v[1] || v[2]) && n < 60) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(v[0] || v[1] || v[2]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int w, nxt[N], cyc;
    for (int i = 0; i < N; i++) begin v[i] = 1'b0; r[i] = '0; d[i] = '0; end
    for (int k = 0; k < 32; k++) begin m_mem[k] = '0; dut_mem[k] = '0; end
    outs_valid = 1'b0; e_known = 1'b0;
    clear_start = 1'b0;
    ctrl_reset  = 1'b1;

    // 1: reset
    step(); step();
    ctrl_reset = 1'b0;
    step();
    chk("rst_writeEn", 32'(s_en), 32'd0);
    chk("rst_writeReg", 32'(s_reg), 32'd0);
    chk("rst_data", s_data, 32'd0);
    chk("rst_busy_done", 32'({s_busy, s_done}), 32'd0);
    chk("rst_reg5", dut_mem[5], 32'd0);

    // 2: single requester
    v[1] = 1'b1; r[1] = 5'd7; d[1] = DEAD;
    step();
    chk("single_ready", 32'(s_ready), 32'b010);
    step();
    chk("single_write", {s_en, 10'd0, s_reg, 16'(s_data)}, {1'b1, 10'd0, 5'd7, 16'hDEAD});
    step();
    chk("single_en_once", 32'(s_en), 32'd0);
    chk("single_reg7", dut_mem[7], DEAD);

    // 3: all three competing after a fresh reset
    ctrl_reset = 1'b1; step(); ctrl_reset = 1'b0;
    for (int i = 0; i < N; i++) nxt[i] = 0;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && nxt[i] < 2) begin
          v[i] = 1'b1;
          r[i] = AW'(i + 1 + 3 * nxt[i]);
          d[i] = 32'(17 * (i + 1 + 3 * nxt[i]));
          nxt[i]++;
        end
      end
      step();
      w = -1;
      for (int i = 0; i < N; i++) if (s_ready[i]) w = i;
      chk("rr_order", 32'(w), 32'(c % 3));
    end
    step();
    for (int k = 1; k <= 6; k++) chk("rr_readback", dut_mem[k], 32'(17 * k));

    // 4: register 0 write counts for round-robin but never writes
    v[0] = 1'b1; r[0] = 5'd0; d[0] = 32'hFFFF_FFFF;
    step();
    chk("reg0_ready", 32'(s_ready), 32'b001);
    v[0] = 1'b1; r[0] = 5'd8; d[0] = 32'h88;
    v[1] = 1'b1; r[1] = 5'd9; d[1] = 32'h99;
    step();
    chk("reg0_no_write", 32'(s_en), 32'd0);
    chk("reg0_next_winner", 32'(s_ready), 32'b010);
    drain_requests();
    step();
    chk("reg0_reads_zero", dut_mem[0], 32'd0);

    // 5: clear with all requesters waiting
    for (int k = 1; k < 32; k++) write_one(0, k, DEAD);
    step();
    for (int i = 0; i < N; i++) begin v[i] = 1'b1; r[i] = AW'(20 + i); d[i] = 32'hA0 + 32'(i); end
    clear_start = 1'b1;
    step();
    chk("clear_blocks_ready", 32'(s_ready), 32'd0);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!s_done && cyc < 40);
    chk("clear_length", 32'(cyc), 32'd32);
    chk("clear_last_write", {s_en, 26'd0, s_reg}, {1'b1, 26'd0, 5'd31});
    chk("clear_resume_ready", 32'(s_ready), 32'b010);
    w = 0;
    for (int k = 1; k < 32; k++) if (dut_mem[k] != 0) w++;
    chk("clear_all_zero", 32'(w), 32'd0);
    drain_requests();

    // 6: reset aborts a clear; a mid-clear re-pulse is ignored
    for (int k = 1; k < 32; k++) write_one(2, k, DEAD);
    step();
    clear_start = 1'b1;
    step();
    for (int c = 1; c <= 10; c++) begin
      if (c == 5) clear_start = 1'b1;
      step();
    end
    ctrl_reset = 1'b1;
    step();
    chk("abort_reg10_written", {s_en, 26'd0, s_reg}, {1'b1, 26'd0, 5'd10});
    ctrl_reset = 1'b0;
    step(); step();
    chk("abort_busy", 32'(s_busy), 32'd0);
    chk("abort_no_done", 32'(s_done), 32'd0);
    chk("abort_reg10", dut_mem[10], 32'd0);
    w = 0;
    for (int k = 11; k < 32; k++) if (dut_mem[k] == DEAD) w++;
    chk("abort_regs_kept", 32'(w), 32'd21);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && ($urandom_range(0, 2) != 0)) begin
          v[i] = 1'b1;
          r[i] = AW'($urandom_range(0, 31));
          d[i] = $urandom;
        end
      end
      if ($urandom_range(0, 59) == 0) clear_start = 1'b1;
      ctrl_reset = ($urandom_range(0, 249) == 0);
      step();
    end
    ctrl_reset = 1'b0;
    drain_requests();
    cyc = 0;
    while (clr_q.size() > 0 && cyc < 40) begin step(); cyc++; end
    step();
    for (int k = 1; k < 32; k++) chk("final_regfile", dut_mem[k], m_mem[k]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
